vdp_raster_timing: RTL

VDP_RASTER_TIMING -- requirements
Module: vdp_raster_timing

---
 rtl/vdp_raster_timing.sv | 125 ++++++++++++
 1 files changed

// File: rtl/vdp_raster_timing.sv
// Raster timing generator for the video display processor.
// Produces pixel/line counters plus sync, blanking and event pulses.
// Every output is a register loaded from the next counter values, so the
// level outputs always describe the raster_x/raster_y shown in the same cycle.
module vdp_raster_timing #(
  parameter int   H_ACTIVE  = 848,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 112,
  parameter int   H_BP      = 112,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 6,
  parameter int   V_SYNC    = 8,
  parameter int   V_BP      = 23,
  parameter logic HSYNC_POL = 1'b1,
  parameter logic VSYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixel_en,
  input  logic [9:0]  irq_line,
  input  logic        irq_enable,
  output logic [10:0] raster_x,
  output logic [9:0]  raster_y,
  output logic        hsync,
  output logic        vsync,
  output logic        hblank,
  output logic        vblank,
  output logic        active_display,
  output logic        line_start,
  output logic        frame_start,
  output logic        line_irq
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Horizontal region boundaries (first column of each region).
  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_FP_START   = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_BP_START   = 11'(H_ACTIVE + H_FP + H_SYNC);

  // Vertical boundaries; V_SYNC_END is the first line after sync.
  localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT_END    = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Horizontal region FSM encoding.
  localparam logic [1:0] S_ACTIVE = 2'd0;
  localparam logic [1:0] S_FRONT  = 2'd1;
  localparam logic [1:0] S_SYNC   = 2'd2;
  localparam logic [1:0] S_BACK   = 2'd3;

  logic [1:0]  h_state;
  logic [1:0]  next_h_state;
  logic [10:0] next_x;
  logic [9:0]  next_y;
  logic        x_wrap;
  logic        y_wrap;

  // Next raster position and horizontal region after one enabled pixel.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    next_h_state = h_state;
    x_wrap       = (raster_x == H_LAST);
    y_wrap       = x_wrap && (raster_y == V_LAST);
    next_x       = x_wrap ? 11'd0 : raster_x + 11'd1;
    next_y       = raster_y;
    if (x_wrap) begin
      next_y = y_wrap ? 10'd0 : raster_y + 10'd1;
    end
    case (h_state)
      S_ACTIVE: if (next_x == H_FP_START)   next_h_state = S_FRONT;
      S_FRONT:  if (next_x == H_SYNC_START) next_h_state = S_SYNC;
      S_SYNC:   if (next_x == H_BP_START)   next_h_state = S_BACK;
      S_BACK:   if (next_x == 11'd0)        next_h_state = S_ACTIVE;
      default:                              next_h_state = S_BACK;
    endcase
  end

  // Counters, FSM and all registered outputs; pulses clear on idle cycles.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (reset) begin
      raster_x       <= H_LAST;
      raster_y       <= V_LAST;
      h_state        <= S_BACK;
      hsync          <= ~HSYNC_POL;
      vsync          <= ~VSYNC_POL;
      hblank         <= 1'b1;
      vblank         <= 1'b1;
      active_display <= 1'b0;
      line_start     <= 1'b0;
      frame_start    <= 1'b0;
      line_irq       <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      line_irq    <= 1'b0;
      if (pixel_en) begin
        raster_x       <= next_x;
        raster_y       <= next_y;
        h_state        <= next_h_state;
        hblank         <= (next_h_state != S_ACTIVE);
        hsync          <= (next_h_state == S_SYNC) ? HSYNC_POL : ~HSYNC_POL;
        // next_y only differs from raster_y on a line wrap, so vsync and
        // vblank can only move when raster_x goes to 0.
        vblank         <= (next_y >= V_ACT_END);
        vsync          <= (next_y >= V_SYNC_START && next_y < V_SYNC_END) ?
                          VSYNC_POL : ~VSYNC_POL;
        active_display <= (next_h_state == S_ACTIVE) && (next_y < V_ACT_END);
        line_start     <= x_wrap;
        frame_start    <= y_wrap;
        // raster_y never reaches V_TOTAL, so an out-of-range irq_line
        // simply never matches.
        line_irq       <= irq_enable && (next_x == H_FP_START) &&
                          (raster_y == irq_line);
      end
    end
  end

endmodule
